// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: Op encodings and FSM state codes.
// Also used by the controller that decodes funct into an Op.
package md_pkg;

  typedef enum logic [3:0] {
    MD_MULT  = 4'h1,
    MD_MULTU = 4'h2,
    MD_DIV   = 4'h3,
    MD_DIVU  = 4'h4,
    MD_MTHI  = 4'h5,
    MD_MTLO  = 4'h6,
    MD_MADD  = 4'h7,
    MD_MADDU = 4'h8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; latency modelled by a down-counter.
// Optional MADD/MADDU support is enabled by defining MD_MADD_EN.
module md_unit
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);

  md_state_e        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [31:0]      hi_q, lo_q, hi_next, lo_next;
  logic             latch;

  // Signed product = low 64 bits of the product of sign-extended operands.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // Signed divide via magnitudes; 0x80000000 / -1 wraps naturally to 0x80000000.
  logic [31:0] divisor, mag_a, mag_b, uq, ur, sq_mag, sr_mag, sq, sr;
  assign divisor = (b_q == 32'd0) ? 32'd1 : b_q;
  assign uq      = a_q / divisor;
  assign ur      = a_q % divisor;
  assign mag_a   = a_q[31] ? (32'd0 - a_q) : a_q;
  assign mag_b   = b_q[31] ? (32'd0 - b_q) : b_q;
  assign sq_mag  = mag_a / ((mag_b == 32'd0) ? 32'd1 : mag_b);
  assign sr_mag  = mag_a % ((mag_b == 32'd0) ? 32'd1 : mag_b);
  assign sq      = (a_q[31] ^ b_q[31]) ? (32'd0 - sq_mag) : sq_mag;
  assign sr      = a_q[31] ? (32'd0 - sr_mag) : sr_mag;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    hi_next    = hi_q;
    lo_next    = lo_q;
    latch      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (Start) begin
          case (Op)
            MD_MULT, MD_MULTU: begin
              latch      = 1'b1;
              cnt_next   = MUL_N;
              state_next = ST_BUSY;
            end
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU: begin
              latch      = 1'b1;
              cnt_next   = MUL_N;
              state_next = ST_BUSY;
            end
`endif
            MD_DIV, MD_DIVU: begin
              latch      = 1'b1;
              cnt_next   = DIV_N;
              state_next = ST_BUSY;
            end
            MD_MTHI: hi_next = A;
            MD_MTLO: lo_next = A;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          case (op_q)
            MD_MULT:  {hi_next, lo_next} = prod_s;
            MD_MULTU: {hi_next, lo_next} = prod_u;
`ifdef MD_MADD_EN
            MD_MADD:  {hi_next, lo_next} = {hi_q, lo_q} + prod_s;
            MD_MADDU: {hi_next, lo_next} = {hi_q, lo_q} + prod_u;
`endif
            MD_DIV:   if (b_q != 32'd0) begin lo_next = sq; hi_next = sr; end
            MD_DIVU:  if (b_q != 32'd0) begin lo_next = uq; hi_next = ur; end
            default: ;
          endcase
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      state <= state_next;
      cnt   <= cnt_next;
      hi_q  <= hi_next;
      lo_q  <= lo_next;
      if (latch) begin
        op_q <= Op;
        a_q  <= A;
        b_q  <= B;
      end
    end
  end

  assign Busy = (state == ST_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
